// File: rtl/fir_sample_scheduler.sv
// Sample-rate scheduler for the time-multiplexed FIR datapath: tick divider with
// shadowed divisor, ADC request, tap-address walk, MAC drain and result handshake.
module fir_sample_scheduler #(
    parameter int NTAPS       = 16,
    parameter int MAC_LAT     = 2,
    parameter int DIV_WIDTH   = 24,
    parameter int DEFAULT_DIV = 12000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     div_load,
    input  logic [DIV_WIDTH-1:0]     div_value,
    output logic                     sample_tick,
    output logic                     adc_req,
    input  logic                     adc_ack,
    output logic [$clog2(NTAPS)-1:0] tap_addr,
    output logic                     mac_clr,
    output logic                     mac_en,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     busy,
    output logic                     overrun,
    input  logic                     overrun_clr
);

    localparam int TAW = $clog2(NTAPS);
    localparam int DCW = $clog2(MAC_LAT) + 1;
    localparam logic [TAW-1:0]       TAP_LAST   = TAW'(NTAPS - 1);
    localparam logic [DCW-1:0]       DRAIN_LAST = DCW'(MAC_LAT - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RESET  = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE    = DIV_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQ,
        S_CLR,
        S_MAC,
        S_DRAIN,
        S_OUT
    } state_t;

    logic [DIV_WIDTH-1:0] count_q, count_d;
    logic [DIV_WIDTH-1:0] active_div_q, active_div_d;
    logic [DIV_WIDTH-1:0] shadow_div_q, shadow_div_d;
    logic [DIV_WIDTH-1:0] div_last;
    logic                 tick;

    state_t               state_q, state_d;
    logic [TAW-1:0]       tap_q, tap_d;
    logic [DCW-1:0]       drain_q, drain_d;

    logic                 adc_req_q, adc_req_d;
    logic                 mac_clr_q, mac_clr_d;
    logic                 mac_en_q, mac_en_d;
    logic                 result_valid_q, result_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;

    // Divisors of 0 and 1 both collapse to a terminal count of 0 (tick every cycle).
    always_comb begin
        div_last = (active_div_q <= DIV_ONE) ? '0 : (active_div_q - DIV_ONE);
        tick     = enable && (count_q == div_last);
    end

    always_comb begin
        count_d      = count_q;
        active_div_d = active_div_q;
        shadow_div_d = shadow_div_q;

        if (!enable || tick) begin
            count_d = '0;
        end else begin
            count_d = count_q + DIV_ONE;
        end

        // The active divisor only changes at a period boundary or while stopped.
        if (tick || !enable) begin
            active_div_d = shadow_div_q;
        end

        if (div_load) begin
            shadow_div_d = div_value;
        end
    end

    always_comb begin
        state_d = state_q;
        tap_d   = '0;
        drain_d = '0;

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_ACQ;
                end
            end
            S_ACQ: begin
                if (adc_ack) begin
                    state_d = S_CLR;
                end
            end
            S_CLR: begin
                state_d = S_MAC;
            end
            S_MAC: begin
                if (tap_q == TAP_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    tap_d = tap_q + TAW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_OUT;
                end else begin
                    drain_d = drain_q + DCW'(1);
                end
            end
            S_OUT: begin
                if (result_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they leave flops directly.
        adc_req_d      = (state_d == S_ACQ);
        mac_clr_d      = (state_d == S_CLR);
        mac_en_d       = (state_d == S_MAC);
        result_valid_d = (state_d == S_OUT);
        busy_d         = (state_d != S_IDLE);

        // Any tick not taken from IDLE is lost; a new loss beats a simultaneous clear.
        if (tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q        <= '0;
            active_div_q   <= DIV_RESET;
            shadow_div_q   <= DIV_RESET;
            state_q        <= S_IDLE;
            tap_q          <= '0;
            drain_q        <= '0;
            adc_req_q      <= 1'b0;
            mac_clr_q      <= 1'b0;
            mac_en_q       <= 1'b0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            count_q        <= count_d;
            active_div_q   <= active_div_d;
            shadow_div_q   <= shadow_div_d;
            state_q        <= state_d;
            tap_q          <= tap_d;
            drain_q        <= drain_d;
            adc_req_q      <= adc_req_d;
            mac_clr_q      <= mac_clr_d;
            mac_en_q       <= mac_en_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
        end
    end

    assign sample_tick  = tick;
    assign adc_req      = adc_req_q;
    assign tap_addr     = tap_q;
    assign mac_clr      = mac_clr_q;
    assign mac_en       = mac_en_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_fir_sample_scheduler.sv
// Directed bench for fir_sample_scheduler (NTAPS=4, MAC_LAT=2, DEFAULT_DIV=10).
module tb_fir_sample_scheduler;

    localparam int NTAPS       = 4;
    localparam int MAC_LAT     = 2;
    localparam int DIV_WIDTH   = 24;
    localparam int DEFAULT_DIV = 10;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 enable = 1'b0;
    logic                 div_load = 1'b0;
    logic [DIV_WIDTH-1:0] div_value = '0;
    logic                 sample_tick;
    logic                 adc_req;
    logic                 adc_ack = 1'b0;
    logic [1:0]           tap_addr;
    logic                 mac_clr;
    logic                 mac_en;
    logic                 result_valid;
    logic                 result_ready = 1'b0;
    logic                 busy;
    logic                 overrun;
    logic                 overrun_clr = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    fir_sample_scheduler #(
        .NTAPS(NTAPS),
        .MAC_LAT(MAC_LAT),
        .DIV_WIDTH(DIV_WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .div_load(div_load),
        .div_value(div_value),
        .sample_tick(sample_tick),
        .adc_req(adc_req),
        .adc_ack(adc_ack),
        .tap_addr(tap_addr),
        .mac_clr(mac_clr),
        .mac_en(mac_en),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy(busy),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tick"}, sample_tick, 0);
        chk({tag, "_adc_req"}, adc_req, 0);
        chk({tag, "_tap"}, tap_addr, 0);
        chk({tag, "_mac_clr"}, mac_clr, 0);
        chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_rvalid"}, result_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    // Cycle 0 is the first observed cycle after release, with enable already high.
    task automatic reset_dut(input string tag);
        enable       = 1'b0;
        div_load     = 1'b0;
        div_value    = '0;
        adc_ack      = 1'b0;
        result_ready = 1'b0;
        overrun_clr  = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero(tag);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        int o;
        logic exp_en;

        // 1: nominal tick rate
        reset_dut("rst1");
        for (int c = 0; c <= 29; c++) begin
            run_to(c);
            chk("t1_tick", sample_tick, (c == 9 || c == 19 || c == 29));
        end

        // 2: full sequence timing with ack and ready held high
        reset_dut("rst2");
        adc_ack      = 1'b1;
        result_ready = 1'b1;
        for (int c = 9; c <= 28; c++) begin
            run_to(c);
            o      = (c - 9) % 10;
            exp_en = (o >= 3 && o <= 6);
            chk("t2_tick", sample_tick, (o == 0));
            chk("t2_adc_req", adc_req, (o == 1));
            chk("t2_mac_clr", mac_clr, (o == 2));
            chk("t2_mac_en", mac_en, exp_en);
            chk("t2_tap", tap_addr, exp_en ? (o - 3) : 0);
            chk("t2_rvalid", result_valid, (o == 9));
            chk("t2_busy", busy, (o >= 1));
            chk("t2_overrun", overrun, 0);
        end

        // 3: overrun set, sticky, clear, and set-wins-over-clear
        reset_dut("rst3");
        adc_ack = 1'b1;
        run_to(18);
        chk("t3_rvalid18", result_valid, 1);
        run_to(19);
        chk("t3_tick19", sample_tick, 1);
        chk("t3_rvalid19", result_valid, 1);
        result_ready = 1'b1;
        run_to(20);
        chk("t3_ovr20", overrun, 1);
        chk("t3_adc_req20", adc_req, 0);
        chk("t3_busy20", busy, 0);
        chk("t3_rvalid20", result_valid, 0);
        run_to(29);
        chk("t3_tick29", sample_tick, 1);
        chk("t3_ovr29", overrun, 1);
        run_to(30);
        chk("t3_adc_req30", adc_req, 1);
        chk("t3_ovr30", overrun, 1);
        overrun_clr = 1'b1;
        run_to(31);
        overrun_clr  = 1'b0;
        result_ready = 1'b0;
        chk("t3_ovr31_cleared", overrun, 0);
        run_to(39);
        chk("t3_rvalid39", result_valid, 1);
        chk("t3_tick39", sample_tick, 1);
        chk("t3_ovr39", overrun, 0);
        overrun_clr = 1'b1;
        run_to(40);
        overrun_clr  = 1'b0;
        chk("t3_ovr40_set_wins", overrun, 1);
        chk("t3_rvalid40", result_valid, 1);
        result_ready = 1'b1;
        run_to(41);
        chk("t3_rvalid41", result_valid, 0);
        chk("t3_ovr41", overrun, 1);

        // 4: divisor reload at period boundary, then divisor 0
        reset_dut("rst4");
        for (int c = 0; c <= 21; c++) begin
            run_to(c);
            if (c == 3) begin
                div_load  = 1'b1;
                div_value = 24'd4;
            end else begin
                div_load = 1'b0;
            end
            chk("t4_tick", sample_tick, (c == 9 || c == 13 || c == 17 || c == 21));
        end
        for (int c = 22; c <= 30; c++) begin
            run_to(c);
            if (c == 22) begin
                div_load  = 1'b1;
                div_value = 24'd0;
            end else begin
                div_load = 1'b0;
            end
            chk("t4_tick_div0", sample_tick, (c >= 25));
        end

        // 5: ADC stall, then enable dropped mid-MAC
        reset_dut("rst5");
        result_ready = 1'b1;
        run_to(9);
        chk("t5_tick9", sample_tick, 1);
        for (int c = 10; c <= 14; c++) begin
            run_to(c);
            chk("t5_adc_req_stall", adc_req, 1);
            chk("t5_mac_clr_stall", mac_clr, 0);
        end
        run_to(15);
        chk("t5_adc_req15", adc_req, 1);
        adc_ack = 1'b1;
        run_to(16);
        adc_ack = 1'b0;
        chk("t5_mac_clr16", mac_clr, 1);
        chk("t5_adc_req16", adc_req, 0);
        run_to(18);
        chk("t5_mac_en18", mac_en, 1);
        chk("t5_tap18", tap_addr, 1);
        enable = 1'b0;
        run_to(20);
        chk("t5_mac_en20", mac_en, 1);
        chk("t5_tap20", tap_addr, 3);
        run_to(21);
        chk("t5_mac_en21", mac_en, 0);
        chk("t5_tap21", tap_addr, 0);
        run_to(23);
        chk("t5_rvalid23", result_valid, 1);
        run_to(24);
        chk("t5_rvalid24", result_valid, 0);
        for (int c = 24; c <= 45; c++) begin
            run_to(c);
            chk("t5_no_tick", sample_tick, 0);
            chk("t5_idle", busy, 0);
        end

        // 6: asynchronous reset in the middle of the MAC walk
        reset_dut("rst6");
        adc_ack      = 1'b1;
        result_ready = 1'b1;
        run_to(1);
        div_load  = 1'b1;
        div_value = 24'd4;
        run_to(2);
        div_load = 1'b0;
        run_to(13);
        chk("t6_mac_en13", mac_en, 1);
        chk("t6_tap13", tap_addr, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        for (int c = 0; c <= 19; c++) begin
            run_to(c);
            chk("t6_tick", sample_tick, (c == 9 || c == 19));
        end
        chk("t6_overrun", overrun, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
